mmio_responder: RTL
===================

# mmio_responder

Memory-mapped I/O responder on the CPU data-memory bus. It answers CPU read/write commands whose address has bit 8 set, while RAM keeps addresses 0x000–0x0FF. It owns the board I/O registers: LEDs, switches, HEX display, a tick timer and a sticky KEY0 event. It sits beside the RAM inside the top level, and the top-level mux selects its `read_data` when `mem_addr[8]` = 1.

## Interface
Parameters:
- `TICK_DIV`, 50000 — `CLOCK_50` cycles per timer tick (1 ms at 50 MHz).

Ports:
- `CLOCK_50`  in  1  — the only clock; all state changes on its rising edge.
- `rst_n`  in  1  — synchronous, active-low reset (top level drives it from `KEY[1]`).
- `mem_cmd`  in  2  — `NONE`=00, `READ`=01, `WRITE`=10; 11 is treated as `NONE`.
- `mem_addr`  in  9  — word address; the block responds only when bit 8 = 1.
- `write_data`  in  16  — write payload.
- `read_data`  out  16  — read payload; valid only while `rdy`=1, 0 otherwise.
- `rdy`  out  1  — one-cycle completion pulse.
- `sw_i`  in  8  — `SW[7:0]`, asynchronous.
- `key0_n_i`  in  1  — `KEY[0]`, active-low, asynchronous.
- `ledr_o`  out  8  — drives `LEDR[7:0]`. `LEDR[9:8]` belong to the CPU.
- `hex0_o`..`hex3_o`  out  7 each — active-low segments.

## Operation
Register map:
- 0x100 LED — R/W, bits [7:0]; reads return zero-extended.
- 0x140 SW — RO, 2-flop-synchronized `sw_i`, zero-extended; writes ignored.
- 0x141 HEX — R/W, 16 bits; nibble n is shown on `hexn_o` as hex 0–F.
- 0x142 TIMER — R/W; 16-bit tick count wrapping 0xFFFF→0. Any write clears it to 0.
- 0x143 STATUS — bit0 is the KEY0 event; writing 1 to bit0 clears it (W1C); other bits read 0.
- Other addresses 0x100–0x1FF — reads return 0, writes are dropped, and `rdy` still pulses.

Handshake state machine:
- States are `IDLE` and `RESP`.
- `IDLE`→`RESP`: accept when `mem_cmd` ∈ {`READ`,`WRITE`} and `mem_addr[8]`=1. A write takes effect at the accept edge. Read data is captured into the response register at the accept edge.
- `RESP`→`IDLE`: unconditional. `rdy`=1 and `read_data` is valid for this one cycle.
- No command is accepted while in `RESP`. The CPU must hold the command until it sees `rdy`, then change it or drop it to `NONE`. A command still present in the cycle after `rdy` is a new transaction.

KEY0 event:
- `key0_n_i` is 2-flop synchronized.
- A falling edge (press) of the synchronized signal sets STATUS bit0.

Timer:
- The prescaler counts 0..`TICK_DIV`−1; the TIMER register increments when the prescaler wraps.

## Timing
- Reset values:
  - `ledr_o`=0 and the HEX register is 0, so all four digits show "0" (7'b1000000).
  - TIMER, prescaler and STATUS are 0.
  - State is `IDLE`; `rdy`=0 and `read_data`=0.
  - Synchronizer flops are 1 for KEY and 0 for SW.
- Latency: accept at edge k puts `rdy` high in cycle k→k+1. Back-to-back accesses are spaced at least 2 cycles apart.
- Read-after-write to the same register returns the new value.
- SW path: a change on `sw_i` is visible to reads 2 edges later.
- Simultaneous events:
  - A TIMER write and a tick on the same edge: the write wins and the result is 0. The prescaler is not reset.
  - A STATUS W1C and a new key press on the same edge: the set wins and bit0 stays 1.
- Reset mid-transaction: a pending `RESP` is abandoned, `rdy` stays 0 and no write is committed. Reset overrides all writes at the same edge.
- Outputs `ledr_o` and `hexn_o` are fully registered or derived only from registers; there are no bus-to-output combinational paths.

## Structure
- Package `mmio_pkg` holds:
  - the `mem_cmd_t` enum (`NONE`/`READ`/`WRITE`);
  - the address constants `MMIO_LED`, `MMIO_SW`, `MMIO_HEX`, `MMIO_TIMER`, `MMIO_STATUS`;
  - the `resp_state_t` enum.
- The CPU and top level import the same package.
- Sub-module `seg7_decoder` maps a 4-bit value to 7 active-low segments. It is instantiated 4× and is the only sub-module.

## Test plan
- Reset with `rst_n`=0 for 2 cycles, then release:
  - `ledr_o`=0, `hex0_o`..`hex3_o`=7'b1000000, `rdy`=0;
  - reading 0x142 returns 0 (or a small count consistent with elapsed ticks when `TICK_DIV`=4).
- WRITE 0x100 with 0x01A5 → `ledr_o`=0xA5 one edge after accept. A following READ 0x100 returns 0x00A5 with `rdy` high exactly 1 cycle.
- Hold `sw_i`=0x3C for ≥2 cycles, then READ 0x140 → 0x003C. Then WRITE 0x140 with 0xFFFF → `rdy` pulses and a re-read still returns 0x003C.
- WRITE 0x141 with 0xBEEF → the digits show B, E, E, F. READ 0x1FF → 0x0000 with `rdy` pulsed.
- With `TICK_DIV`=4:
  - 20 idle cycles → TIMER reads 5.
  - A WRITE to 0x142 aligned with a tick edge → the next read returns 0.
- KEY0 and reset:
  - Pulse `key0_n_i` low → STATUS reads 1.
  - W1C on the same edge as a new press → STATUS stays 1; a second W1C → 0.
  - Assert `rst_n` in the `RESP` cycle of a WRITE to 0x100 → no `rdy` and `ledr_o`=0.

Source files
------------

// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared bus command, register map and responder state definitions
package mmio_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10
    } mem_cmd_t;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } resp_state_t;

    localparam logic [8:0] MMIO_LED    = 9'h100;
    localparam logic [8:0] MMIO_SW     = 9'h140;
    localparam logic [8:0] MMIO_HEX    = 9'h141;
    localparam logic [8:0] MMIO_TIMER  = 9'h142;
    localparam logic [8:0] MMIO_STATUS = 9'h143;

    // Bit 8 of the word address splits the bus between RAM and this block.
    function automatic logic is_mmio(input logic [8:0] addr);
        return addr[8];
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - hex nibble to active-low seven-segment pattern
//
// Ports:
//   value  in  4  nibble to display (0-F)
//   seg    out 7  segments {g,f,e,d,c,b,a}, 0 = lit
module seg7_decoder (
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (value)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/mmio_responder.sv
// rtl/mmio_responder.sv - CPU bus responder for board I/O registers (LED, SW, HEX, timer, KEY0 status)
//
// Ports:
//   CLOCK_50    in   1   clock, all state on rising edge
//   rst_n       in   1   synchronous active-low reset
//   mem_cmd     in   2   NONE/READ/WRITE (2'b11 behaves as NONE)
//   mem_addr    in   9   word address, responds when bit 8 is set
//   write_data  in  16   write payload
//   read_data   out 16   read payload while rdy, else 0
//   rdy         out  1   one-cycle completion pulse
//   sw_i        in   8   switches, asynchronous
//   key0_n_i    in   1   KEY0, active-low, asynchronous
//   ledr_o      out  8   LED register
//   hex0_o..3   out  7   active-low digits of the HEX register
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int TICK_DIV = 50000
) (
    input  logic        CLOCK_50,
    input  logic        rst_n,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        rdy,
    input  logic [7:0]  sw_i,
    input  logic        key0_n_i,
    output logic [7:0]  ledr_o,
    output logic [6:0]  hex0_o,
    output logic [6:0]  hex1_o,
    output logic [6:0]  hex2_o,
    output logic [6:0]  hex3_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    resp_state_t state;
    resp_state_t next_state;

    logic        accept;
    logic        rd_en;
    logic        wr_en;
    logic [15:0] rd_mux;
    logic [15:0] resp_data;

    logic [7:0]  led;
    logic [15:0] hex_reg;
    logic [15:0] timer;
    logic [PW-1:0] presc;
    logic        tick;
    logic        status;

    logic [7:0]  sw_meta;
    logic [7:0]  sw_sync;
    logic        key_meta;
    logic        key_sync;
    logic        key_prev;
    logic        key_press;

    // Handshake FSM: one accept per IDLE visit, RESP always lasts one cycle.
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if ((mem_cmd == READ || mem_cmd == WRITE) && is_mmio(mem_addr)) begin
                    accept     = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign rd_en = accept && (mem_cmd == READ);
    assign wr_en = accept && (mem_cmd == WRITE);

    assign tick      = (presc == PW'(TICK_DIV - 1));
    assign key_press = key_prev & ~key_sync;

    always_comb begin
        rd_mux = '0;
        case (mem_addr)
            MMIO_LED:    rd_mux = {8'h00, led};
            MMIO_SW:     rd_mux = {8'h00, sw_sync};
            MMIO_HEX:    rd_mux = hex_reg;
            MMIO_TIMER:  rd_mux = timer;
            MMIO_STATUS: rd_mux = {15'h0000, status};
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            led       <= '0;
            hex_reg   <= '0;
            timer     <= '0;
            presc     <= '0;
            status    <= 1'b0;
            resp_data <= '0;
            sw_meta   <= '0;
            sw_sync   <= '0;
            key_meta  <= 1'b1;
            key_sync  <= 1'b1;
            key_prev  <= 1'b1;
        end else begin
            sw_meta  <= sw_i;
            sw_sync  <= sw_meta;
            key_meta <= key0_n_i;
            key_sync <= key_meta;
            key_prev <= key_sync;

            presc <= tick ? '0 : presc + PW'(1);

            // A bus clear beats a coincident tick; the prescaler keeps running.
            if (wr_en && mem_addr == MMIO_TIMER) begin
                timer <= '0;
            end else if (tick) begin
                timer <= timer + 16'd1;
            end

            // A fresh press beats a coincident W1C so the event is never lost.
            if (key_press) begin
                status <= 1'b1;
            end else if (wr_en && mem_addr == MMIO_STATUS && write_data[0]) begin
                status <= 1'b0;
            end

            if (wr_en && mem_addr == MMIO_LED) begin
                led <= write_data[7:0];
            end
            if (wr_en && mem_addr == MMIO_HEX) begin
                hex_reg <= write_data;
            end

            // Register contents before this edge's write; writes respond with 0.
            if (accept) begin
                resp_data <= rd_en ? rd_mux : '0;
            end
        end
    end

    // Gating with rst_n drops a response that reset is abandoning.
    assign rdy       = (state == RESP) && rst_n;
    assign read_data = rdy ? resp_data : '0;
    assign ledr_o    = led;

    seg7_decoder u_hex0 (.value(hex_reg[3:0]),   .seg(hex0_o));
    seg7_decoder u_hex1 (.value(hex_reg[7:4]),   .seg(hex1_o));
    seg7_decoder u_hex2 (.value(hex_reg[11:8]),  .seg(hex2_o));
    seg7_decoder u_hex3 (.value(hex_reg[15:12]), .seg(hex3_o));

endmodule
